rect_fill_writer: RTL

Framebuffer writer that fills an axis-aligned rectangle with one colour, one pixel per accepted cycle. It is the write-side counterpart of the VGA scan-out path: game logic issues draw commands here, and this block produces address/data/write-enable beats into the shared video memory that the VGA controller reads. Coordinates are clipped to the framebuffer, so every accepted write lands in range.

---
 rtl/rect_fill_writer_if.sv | 39 +++
 rtl/rect_fill_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_writer_if.sv
// ---------------------------------------------------------------------------
// rect_fill_writer_if
// Write-side video memory bus between the rectangle fill writer and the
// shared framebuffer / arbiter.
//
// Signals:
//   mem_addr   write address (y*FB_WIDTH + x)
//   mem_data   pixel colour to write
//   mem_we     write valid
//   mem_grant  memory/arbiter ready; a beat transfers on a rising edge
//              where mem_we && mem_grant
//
// Modports:
//   master  the fill writer (drives addr/data/we, observes grant)
//   slave   the memory/arbiter side (observes addr/data/we, drives grant)
// ---------------------------------------------------------------------------
interface rect_fill_writer_if #(
  parameter int ADDR_W   = 15,
  parameter int COLOUR_W = 6
) ();
  logic [ADDR_W-1:0]   mem_addr;
  logic [COLOUR_W-1:0] mem_data;
  logic                mem_we;
  logic                mem_grant;

  modport master (
    output mem_addr,
    output mem_data,
    output mem_we,
    input  mem_grant
  );

  modport slave (
    input  mem_addr,
    input  mem_data,
    input  mem_we,
    output mem_grant
  );
endinterface

// File: rtl/rect_fill_writer.sv
// ---------------------------------------------------------------------------
// rect_fill_writer
// Fills an axis-aligned rectangle of the framebuffer with one colour, one
// pixel per accepted bus beat, in row-major order. The rectangle is clipped
// to the framebuffer so every write lands in range.
//
// Optional feature: define RECT_FILL_OUTLINE_EN to add the 'outline' input;
// when set with a command only the border of the clipped rectangle is drawn.
// Without the macro every command is a solid fill and the port is absent.
//
// Ports:
//   vga_clock  single clock, all state on rising edge
//   resetn     asynchronous active-low reset
//   start      command strobe, sampled only while idle
//   x0, y0     top-left corner of the rectangle
//   w, h       rectangle width / height in pixels
//   colour     fill colour (RRGGBB)
//   outline    border-only draw (RECT_FILL_OUTLINE_EN only)
//   busy       high whenever a command is in progress
//   done       one-cycle pulse when a command completes
//   mem        write bus (rect_fill_writer_if, master side)
// ---------------------------------------------------------------------------
module rect_fill_writer #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int ADDR_W    = 15,
  parameter int COLOUR_W  = 6
) (
  input  logic                vga_clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [9:0]          x0,
  input  logic [8:0]          y0,
  input  logic [9:0]          w,
  input  logic [8:0]          h,
  input  logic [COLOUR_W-1:0] colour,
`ifdef RECT_FILL_OUTLINE_EN
  input  logic                outline,
`endif
  output logic                busy,
  output logic                done,
  rect_fill_writer_if.master  mem
);

  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_WIDTH);
  localparam logic [10:0]       FB_W11 = 11'(FB_WIDTH);
  localparam logic [9:0]        FB_H10 = 10'(FB_HEIGHT);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t              state_q, state_d;
  logic [9:0]          x0_q, x0_d;
  logic [8:0]          y0_q, y0_d;
  logic [9:0]          w_q, w_d;
  logic [8:0]          h_q, h_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic [10:0]         xe_q, xe_d;
  logic [9:0]          ye_q, ye_d;
  logic [9:0]          cx_q, cx_d;
  logic [8:0]          cy_q, cy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COLOUR_W-1:0] data_q, data_d;
  logic                we_q, we_d;

`ifdef RECT_FILL_OUTLINE_EN
  logic outline_q, outline_d;
`else
  logic outline_q;
  assign outline_q = 1'b0;
`endif

  // Clipped bounds and per-beat helper terms. Sums are one bit wider than
  // the operands so a large x0+w or y0+h never wraps before clipping.
  logic [10:0] sum_x, xe_clip, cx_inc, row_span_m1;
  logic [9:0]  sum_y, ye_clip, cy_inc;
  logic        degenerate, xfer, interior_row;

  always_comb begin
    sum_x        = {1'b0, x0_q} + {1'b0, w_q};
    sum_y        = {1'b0, y0_q} + {1'b0, h_q};
    xe_clip      = (sum_x > FB_W11) ? FB_W11 : sum_x;
    ye_clip      = (sum_y > FB_H10) ? FB_H10 : sum_y;
    degenerate   = (w_q == 10'd0) || (h_q == 9'd0) ||
                   ({1'b0, x0_q} >= FB_W11) || ({1'b0, y0_q} >= FB_H10);
    cx_inc       = {1'b0, cx_q} + 11'd1;
    cy_inc       = {1'b0, cy_q} + 10'd1;
    // Distance from the first to the last column of the clipped row.
    row_span_m1  = xe_q - {1'b0, x0_q} - 11'd1;
    xfer         = we_q && mem.mem_grant;
    interior_row = (cy_q != y0_q) && (cy_inc != ye_q);
  end

  // Next-state and next-output logic for the command FSM. The bus outputs
  // only move on a transfer edge, so a stalled beat is held exactly as is.
  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    colour_d  = colour_q;
    xe_d      = xe_q;
    ye_d      = ye_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = we_q;
`ifdef RECT_FILL_OUTLINE_EN
    outline_d = outline_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d      = x0;
          y0_d      = y0;
          w_d       = w;
          h_d       = h;
          colour_d  = colour;
`ifdef RECT_FILL_OUTLINE_EN
          outline_d = outline;
`endif
          state_d   = SETUP;
        end
      end
      SETUP: begin
        xe_d = xe_clip;
        ye_d = ye_clip;
        if (degenerate) begin
          state_d = DONE;
        end else begin
          addr_d  = ADDR_W'(y0_q) * FB_W_A + ADDR_W'(x0_q);
          cx_d    = x0_q;
          cy_d    = y0_q;
          data_d  = colour_q;
          we_d    = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (xfer) begin
          if (cx_inc < xe_q) begin
            // Interior rows of an outline skip straight to the right edge.
            if (outline_q && interior_row && (cx_q == x0_q)) begin
              cx_d   = xe_q[9:0] - 10'd1;
              addr_d = addr_q + ADDR_W'(row_span_m1);
            end else begin
              cx_d   = cx_q + 10'd1;
              addr_d = addr_q + ADDR_W'(1);
            end
          end else if (cy_inc < ye_q) begin
            cy_d   = cy_q + 9'd1;
            cx_d   = x0_q;
            addr_d = addr_q + FB_W_A - ADDR_W'(row_span_m1);
          end else begin
            we_d    = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  // State register; reset drops any in-flight command immediately.
  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      colour_q  <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
`ifdef RECT_FILL_OUTLINE_EN
      outline_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      w_q       <= w_d;
      h_q       <= h_d;
      colour_q  <= colour_d;
      xe_q      <= xe_d;
      ye_q      <= ye_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
`ifdef RECT_FILL_OUTLINE_EN
      outline_q <= outline_d;
`endif
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign mem.mem_addr = addr_q;
  assign mem.mem_data = data_q;
  assign mem.mem_we   = we_q;

endmodule
